// File: rtl/prod_accum_pkg.sv
// Shared types and sizing helpers for the product accumulator.
package prod_accum_pkg;

  // Legacy state encodings, kept as named constants so existing decode logic can reuse them.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ACCUM = ST_ACCUM,
    HOLD  = ST_HOLD
  } state_t;

  localparam int unsigned PW_DEF    = 8;
  localparam int unsigned LEN_DEF   = 16;
  localparam int unsigned ACC_W_DEF = 12;
  localparam int unsigned CW_DEF    = 5;

  // Legal sizing: accumulator at least as wide as a product, and the term counter
  // able to represent LEN (1..2^CW-1).
  function automatic bit sizes_ok(input int unsigned pw, input int unsigned len,
                                  input int unsigned acc_w, input int unsigned cw);
    longint unsigned span;
    span = 64'd1 << cw;
    return (acc_w >= pw) && (len >= 1) && (cw < 32) && (span > longint'(len));
  endfunction

  localparam bit ACC_W_COVERS_PW = (ACC_W_DEF >= PW_DEF);
  localparam bit CW_COVERS_LEN   = ((64'd1 << CW_DEF) > LEN_DEF);
  localparam bit DEF_SIZES_OK    = sizes_ok(PW_DEF, LEN_DEF, ACC_W_DEF, CW_DEF);

endpackage

// File: rtl/acc_add_sat.sv
// Combinational accumulate step: acc + zero-extended product.
// With PROD_ACC_SAT_EN defined the sum clamps to all-ones on carry out and ovf
// reports the carry; otherwise the sum wraps and ovf is constant 0.
module acc_add_sat #(
  parameter int unsigned PW    = 8,
  parameter int unsigned ACC_W = 12
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [PW-1:0]    prod,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

`ifdef PROD_ACC_SAT_EN
  logic [ACC_W:0] wide;

  // Add one bit wider so the carry out marks overflow, then clamp.
  always_comb begin
    wide = {1'b0, acc} + (ACC_W+1)'(prod);
    ovf  = wide[ACC_W];
    sum  = ovf ? '1 : wide[ACC_W-1:0];
  end
`else
  // Modular add; overflow is not reported when wrapping.
  always_comb begin
    sum = acc + ACC_W'(prod);
    ovf = 1'b0;
  end
`endif

endmodule

// File: rtl/prod_accum.sv
// Product accumulator: sums a group of multiplier products (closed by in_last or
// after LEN beats) and holds the result until the sink accepts it.
// Optional saturation and overflow reporting: define PROD_ACC_SAT_EN.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int unsigned PW    = 8,
  parameter int unsigned LEN   = 16,
  parameter int unsigned ACC_W = 12,
  parameter int unsigned CW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PW-1:0]    in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CW-1:0]    out_cnt,
  output logic             out_ovf
);

  if (!sizes_ok(PW, LEN, ACC_W, CW)) begin : g_bad_sizes
    $error("prod_accum: illegal sizing (need ACC_W >= PW, 1 <= LEN < 2**CW)");
  end

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CW-1:0]    cnt;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic             accept;
  logic             closes;

  acc_add_sat #(.PW(PW), .ACC_W(ACC_W)) u_add (
    .acc  (acc),
    .prod (in_prod),
    .sum  (add_sum),
    .ovf  (add_ovf)
  );

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign closes    = in_last || (cnt == CW'(LEN - 1));

  // Group FSM, running sum/count and result registers; clr aborts like reset.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      out_sum <= '0;
      out_cnt <= '0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            if (closes) begin
              out_sum <= add_sum;
              out_cnt <= cnt + CW'(1);
              acc     <= '0;
              cnt     <= '0;
              state   <= HOLD;
            end else begin
              acc     <= add_sum;
              cnt     <= cnt + CW'(1);
              state   <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PROD_ACC_SAT_EN
  logic ovf_sticky;
  logic out_ovf_q;

  // Sticky overflow across the group, latched into the result on the closing beat.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ovf_sticky <= 1'b0;
      out_ovf_q  <= 1'b0;
    end else if (accept) begin
      if (closes) begin
        out_ovf_q  <= ovf_sticky | add_ovf;
        ovf_sticky <= 1'b0;
      end else begin
        ovf_sticky <= ovf_sticky | add_ovf;
      end
    end
  end

  assign out_ovf = out_ovf_q;
`else
  // The adder drives ovf constant 0 when wrapping.
  assign out_ovf = add_ovf;
`endif

endmodule
